// File: rtl/rr_arb_mux_2to1_if.sv
// rr_arb_mux_2to1_if
//   Bundles the two producer streams and the single registered consumer stream
//   of the round-robin arbiter.
//   master : arbiter side (drives readies, y_valid, y_data, sel)
//   slave  : environment side (drives valids, data, y_ready)
//   Signals:
//     i0_valid/i0_data/i0_ready : channel 0 producer handshake
//     i1_valid/i1_data/i1_ready : channel 1 producer handshake
//     y_valid/y_data/y_ready    : registered output handshake
//     sel                       : registered source of y_data (0 = i0, 1 = i1)
interface rr_arb_mux_2to1_if #(
  parameter int DATA_W = 8
);
  logic              i0_valid;
  logic [DATA_W-1:0] i0_data;
  logic              i0_ready;
  logic              i1_valid;
  logic [DATA_W-1:0] i1_data;
  logic              i1_ready;
  logic              y_valid;
  logic [DATA_W-1:0] y_data;
  logic              y_ready;
  logic              sel;

  modport master (
    input  i0_valid, i0_data, i1_valid, i1_data, y_ready,
    output i0_ready, i1_ready, y_valid, y_data, sel
  );

  modport slave (
    output i0_valid, i0_data, i1_valid, i1_data, y_ready,
    input  i0_ready, i1_ready, y_valid, y_data, sel
  );
endinterface

// File: rtl/rr_arb_mux_2to1.sv
// rr_arb_mux_2to1
//   Registered two-channel stream arbiter feeding the 2-to-1 mux stage.
//   Picks one of two valid/ready producers per cycle with round-robin
//   fairness, holds the winner in a single output register, and reports the
//   source index (sel) alongside the word. Per-channel grant counters wrap
//   modulo 2^CNT_W.
//   Ports:
//     clk      : rising-edge clock
//     rst_n    : asynchronous active-low reset
//     bus      : stream interface (master modport), see rr_arb_mux_2to1_if
//     gnt0_cnt : words accepted from channel 0
//     gnt1_cnt : words accepted from channel 1
module rr_arb_mux_2to1 #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rr_arb_mux_2to1_if.master    bus,
  output logic [CNT_W-1:0]     gnt0_cnt,
  output logic [CNT_W-1:0]     gnt1_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic              last_grant_q;
  logic [DATA_W-1:0] data_q;
  logic              sel_q;
  logic [CNT_W-1:0]  cnt0_q, cnt1_q;

  logic              can_load;
  logic              gnt_any;
  logic              gnt_idx;
  logic              load;

  // Grant, handshake and next-state decode.
  always_comb begin
    state_d      = state_q;
    can_load     = 1'b0;
    gnt_any      = 1'b0;
    gnt_idx      = 1'b0;
    load         = 1'b0;
    bus.i0_ready = 1'b0;
    bus.i1_ready = 1'b0;

    can_load = (state_q == EMPTY) || bus.y_ready;
    gnt_any  = bus.i0_valid | bus.i1_valid;

    // Under contention the channel that did not win last time gets the slot;
    // otherwise whichever channel is requesting wins.
    if (bus.i0_valid && bus.i1_valid) begin
      gnt_idx = ~last_grant_q;
    end else begin
      gnt_idx = bus.i1_valid;
    end

    load         = can_load & gnt_any;
    bus.i0_ready = load & ~gnt_idx & bus.i0_valid;
    bus.i1_ready = load &  gnt_idx & bus.i1_valid;

    unique case (state_q)
      EMPTY: begin
        if (load) state_d = FULL;
      end
      FULL: begin
        if (load)             state_d = FULL;
        else if (bus.y_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Output register, round-robin pointer and grant counters. Data only moves
  // on a load, so the unselected channel's data never reaches y_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q       <= '0;
      sel_q        <= 1'b0;
      last_grant_q <= 1'b1;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else if (load) begin
      data_q       <= gnt_idx ? bus.i1_data : bus.i0_data;
      sel_q        <= gnt_idx;
      last_grant_q <= gnt_idx;
      if (gnt_idx) cnt1_q <= cnt1_q + 1'b1;
      else         cnt0_q <= cnt0_q + 1'b1;
    end
  end

  assign bus.y_valid = (state_q == FULL);
  assign bus.y_data  = data_q;
  assign bus.sel     = sel_q;
  assign gnt0_cnt    = cnt0_q;
  assign gnt1_cnt    = cnt1_q;

endmodule

// File: tb/tb_rr_arb_mux_2to1.sv
// tb_rr_arb_mux_2to1
//   Directed-vector bench for rr_arb_mux_2to1. The driver applies one vector
//   per cycle on the falling edge, checks the hand-computed readies, and queues
//   the word expected on the output. A separate monitor compares the output
//   register against the queue head every cycle. A second instance with
//   CNT_W=2 exercises counter wrap.
module tb_rr_arb_mux_2to1;

  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rr_arb_mux_2to1_if #(.DATA_W(DATA_W)) bus_a ();
  rr_arb_mux_2to1_if #(.DATA_W(DATA_W)) bus_b ();

  logic [7:0] a_cnt0, a_cnt1;
  logic [1:0] b_cnt0, b_cnt1;

  rr_arb_mux_2to1 #(.DATA_W(DATA_W), .CNT_W(8)) dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus_a.master),
    .gnt0_cnt (a_cnt0),
    .gnt1_cnt (a_cnt1)
  );

  rr_arb_mux_2to1 #(.DATA_W(DATA_W), .CNT_W(2)) dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus_b.master),
    .gnt0_cnt (b_cnt0),
    .gnt1_cnt (b_cnt1)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              sel;
    int                cyc;
  } exp_t;

  exp_t q[$];
  int   cyc_cnt = 0;
  int   n_chk   = 0;
  int   n_pass  = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // One stimulus cycle on DUT A with hand-computed readies.
  task automatic cyc(input logic v0, input logic [7:0] d0,
                     input logic v1, input logic [7:0] d1,
                     input logic yr, input logic er0, input logic er1);
    exp_t e;
    @(negedge clk);
    bus_a.i0_valid = v0; bus_a.i0_data = d0;
    bus_a.i1_valid = v1; bus_a.i1_data = d1;
    bus_a.y_ready  = yr;
    #1;
    chk("i0_ready", {31'd0, bus_a.i0_ready}, {31'd0, er0});
    chk("i1_ready", {31'd0, bus_a.i1_ready}, {31'd0, er1});
    if (er0 || er1) begin
      e.data = er1 ? d1 : d0;
      e.sel  = er1;
      e.cyc  = cyc_cnt;
      q.push_back(e);
    end
  endtask

  task automatic chk_cnt(input logic [7:0] e0, input logic [7:0] e1);
    chk("gnt0_cnt", {24'd0, a_cnt0}, {24'd0, e0});
    chk("gnt1_cnt", {24'd0, a_cnt1}, {24'd0, e1});
  endtask

  // Reset asserted between clock edges; outputs must clear without an edge.
  task automatic do_reset();
    @(negedge clk);
    bus_a.i0_valid = 1'b0; bus_a.i1_valid = 1'b0; bus_a.y_ready = 1'b0;
    bus_a.i0_data  = '0;   bus_a.i1_data  = '0;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_y_valid", {31'd0, bus_a.y_valid}, 32'd0);
    chk("rst_y_data",  {24'd0, bus_a.y_data},  32'd0);
    chk("rst_sel",     {31'd0, bus_a.sel},     32'd0);
    chk_cnt(8'd0, 8'd0);
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: output register must hold the oldest queued word from the cycle
  // after its handshake until the consumer takes it.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        logic exp_v;
        exp_v = (q.size() > 0) && (q[0].cyc < cyc_cnt);
        chk("y_valid", {31'd0, bus_a.y_valid}, {31'd0, exp_v});
        if (exp_v) begin
          chk("y_data", {24'd0, bus_a.y_data}, {24'd0, q[0].data});
          chk("sel",    {31'd0, bus_a.sel},    {31'd0, q[0].sel});
          if (bus_a.y_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    int wrap_exp[5];
    wrap_exp = '{1, 2, 3, 0, 1};

    bus_a.i0_valid = 1'b0; bus_a.i1_valid = 1'b0; bus_a.y_ready = 1'b0;
    bus_a.i0_data  = '0;   bus_a.i1_data  = '0;
    bus_b.i0_valid = 1'b0; bus_b.i1_valid = 1'b0; bus_b.y_ready = 1'b0;
    bus_b.i0_data  = '0;   bus_b.i1_data  = '0;

    // Reset then idle
    do_reset();
    cyc(0, 8'h00, 0, 8'h00, 1, 0, 0);
    cyc(0, 8'h00, 0, 8'h00, 1, 0, 0);
    chk_cnt(8'd0, 8'd0);

    // Single source
    do_reset();
    cyc(1, 8'hA5, 0, 8'h00, 1, 1, 0);
    cyc(0, 8'h00, 0, 8'h00, 1, 0, 0);
    chk_cnt(8'd1, 8'd0);
    cyc(0, 8'h00, 0, 8'h00, 1, 0, 0);

    // Contention: strict alternation starting with channel 0
    do_reset();
    cyc(1, 8'h11, 1, 8'h22, 1, 1, 0);
    cyc(1, 8'h11, 1, 8'h22, 1, 0, 1);
    cyc(1, 8'h11, 1, 8'h22, 1, 1, 0);
    cyc(1, 8'h11, 1, 8'h22, 1, 0, 1);
    cyc(0, 8'h00, 0, 8'h00, 1, 0, 0);
    chk_cnt(8'd2, 8'd2);
    cyc(0, 8'h00, 0, 8'h00, 1, 0, 0);

    // Backpressure: stall holds 0x3C, release accepts i0 in the same cycle
    do_reset();
    cyc(0, 8'h00, 1, 8'h3C, 1, 0, 1);
    cyc(1, 8'h55, 0, 8'h00, 0, 0, 0);
    cyc(1, 8'h55, 0, 8'h00, 0, 0, 0);
    cyc(1, 8'h55, 0, 8'h00, 0, 0, 0);
    cyc(1, 8'h55, 0, 8'h00, 1, 1, 0);
    cyc(0, 8'h00, 0, 8'h00, 1, 0, 0);
    chk_cnt(8'd1, 8'd1);
    cyc(0, 8'h00, 0, 8'h00, 1, 0, 0);

    // Async reset while FULL, then channel 0 wins first contention
    cyc(1, 8'h77, 1, 8'h88, 0, 0, 1);
    cyc(0, 8'h00, 0, 8'h00, 0, 0, 0);
    do_reset();
    cyc(1, 8'hAA, 1, 8'hBB, 1, 1, 0);
    cyc(1, 8'hAA, 1, 8'hBB, 1, 0, 1);
    cyc(0, 8'h00, 0, 8'h00, 1, 0, 0);
    chk_cnt(8'd1, 8'd1);
    cyc(0, 8'h00, 0, 8'h00, 1, 0, 0);

    // Counter wrap on the CNT_W=2 instance: five i1-only transfers
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus_b.i1_valid = 1'b1; bus_b.i1_data = 8'(8'h40 + i); bus_b.y_ready = 1'b1;
      #1;
      chk("b_i1_ready", {31'd0, bus_b.i1_ready}, 32'd1);
      if (i > 0) chk("b_gnt1_cnt", {30'd0, b_cnt1}, 32'(wrap_exp[i-1]));
    end
    @(negedge clk);
    bus_b.i1_valid = 1'b0;
    #1;
    chk("b_gnt1_cnt", {30'd0, b_cnt1}, 32'(wrap_exp[4]));
    chk("b_gnt0_cnt", {30'd0, b_cnt0}, 32'd0);

    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
